// File: rtl/spi1_pkg.sv
// Shared command-byte layout, address width and FSM state encoding for the SPI1 target.
package spi1_pkg;
    localparam int ADDR_WIDTH   = 17;
    localparam int RW_N_BIT     = 7;
    localparam int SET_ADDR_BIT = 6;
    localparam int A16_BIT      = 0;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        ADDR_HI,
        ADDR_LO,
        DONE
    } state_t;
endpackage

// File: rtl/spi_target_shift.sv
// SPI mode-0 bit engine: pin synchronizers, SCK edge detect, RX byte assembly and TX shift-out.
// Byte strobe one clk after the 8th synchronized SCK rise; no backpressure, held in reset while CS is high.
module spi_target_shift (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sck,
    input  logic       i_cs_n,
    input  logic       i_pico,
    input  logic [7:0] i_tx_byte,
    output logic       o_poci,
    output logic       o_cs_fall,
    output logic       o_cs_rise,
    output logic       o_byte_vld,
    output logic [7:0] o_byte_dat
);
    logic [1:0] r_sck_sync;
    logic [1:0] r_cs_sync;
    logic [1:0] r_pico_sync;
    logic       r_sck_d;
    logic       r_cs_d;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx;
    logic [7:0] r_tx;
    logic       r_byte_vld;

    logic w_sck;
    logic w_cs_n;
    logic w_pico;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_fall;

    assign w_sck      = r_sck_sync[1];
    assign w_cs_n     = r_cs_sync[1];
    assign w_pico     = r_pico_sync[1];
    assign w_sck_rise = w_sck & ~r_sck_d & ~w_cs_n;
    assign w_sck_fall = ~w_sck & r_sck_d & ~w_cs_n;
    assign w_cs_fall  = ~w_cs_n & r_cs_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sck_sync  <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_pico_sync <= 2'b00;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[0], i_sck};
            r_cs_sync   <= {r_cs_sync[0], i_cs_n};
            r_pico_sync <= {r_pico_sync[0], i_pico};
            r_sck_d     <= w_sck;
            r_cs_d      <= w_cs_n;
        end
    end

    // TX is loaded once per frame, so bytes after the first shift out zeros.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt  <= 3'd0;
            r_rx       <= 8'h00;
            r_tx       <= 8'h00;
            r_byte_vld <= 1'b0;
        end else if (w_cs_n) begin
            r_bit_cnt  <= 3'd0;
            r_rx       <= 8'h00;
            r_tx       <= 8'h00;
            r_byte_vld <= 1'b0;
        end else begin
            r_byte_vld <= w_sck_rise && (r_bit_cnt == 3'd7);
            if (w_sck_rise) begin
                r_rx      <= {r_rx[6:0], w_pico};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_cs_fall) begin
                r_tx <= i_tx_byte;
            end else if (w_sck_fall) begin
                r_tx <= {r_tx[6:0], 1'b0};
            end
        end
    end

    assign o_poci     = r_tx[7];
    assign o_cs_fall  = w_cs_fall;
    assign o_cs_rise  = w_cs_n & ~r_cs_d;
    assign o_byte_vld = r_byte_vld;
    assign o_byte_dat = r_rx;
endmodule

// File: rtl/spi1_target.sv
// SPI1 target: decodes command frames into single-byte bus requests; valid_o 1 clk after the final byte strobe.
// Requests hold until ready_i; a request decoded while one is pending is dropped with an overrun_o pulse.
module spi1_target
    import spi1_pkg::*;
#(
    parameter int CLK_MHZ = 64,
    parameter int SCK_MHZ = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  spi_sck_i,
    input  logic                  spi_cs_ni,
    input  logic                  spi_pico_i,
    output logic                  spi_poci_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [7:0]            wr_data_o,
    output logic                  we_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic [7:0]            rd_data_i,
    output logic                  overrun_o
);
    localparam bit RATIO_OK = (2 * CLK_MHZ >= 5 * SCK_MHZ);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_rw_n;
    logic                  r_set_addr;
    logic                  r_a16;
    logic [7:0]            r_data;
    logic [7:0]            r_addr_hi;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_valid;
    logic                  r_we;
    logic [7:0]            r_wr_data;
    logic                  r_overrun;
    logic [7:0]            r_rd_buf;

    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_byte_vld;
    logic [7:0] w_byte;
    logic       w_issue;
    logic       w_load;
    logic       w_cap_cmd;
    logic       w_cap_data;
    logic       w_cap_hi;
    logic       w_rw_n;
    logic [7:0] w_wdat;

    spi_target_shift u_shift (
        .i_clk      (clk_i),
        .i_rst_n    (rst_ni),
        .i_sck      (spi_sck_i),
        .i_cs_n     (spi_cs_ni),
        .i_pico     (spi_pico_i),
        .i_tx_byte  (r_rd_buf),
        .o_poci     (spi_poci_o),
        .o_cs_fall  (w_cs_fall),
        .o_cs_rise  (w_cs_rise),
        .o_byte_vld (w_byte_vld),
        .o_byte_dat (w_byte)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_load      = 1'b0;
        w_cap_cmd   = 1'b0;
        w_cap_data  = 1'b0;
        w_cap_hi    = 1'b0;
        w_rw_n      = r_rw_n;
        w_wdat      = r_data;
        if (w_cs_rise) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: if (w_cs_fall) w_state_nxt = CMD;
                CMD: if (w_byte_vld) begin
                    w_cap_cmd = 1'b1;
                    w_rw_n    = w_byte[RW_N_BIT];
                    if (!w_byte[RW_N_BIT])         w_state_nxt = DATA;
                    else if (w_byte[SET_ADDR_BIT]) w_state_nxt = ADDR_HI;
                    else begin
                        w_issue     = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
                DATA: if (w_byte_vld) begin
                    w_cap_data = 1'b1;
                    w_wdat     = w_byte;
                    if (r_set_addr) w_state_nxt = ADDR_HI;
                    else begin
                        w_issue     = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
                ADDR_HI: if (w_byte_vld) begin
                    w_cap_hi    = 1'b1;
                    w_state_nxt = ADDR_LO;
                end
                ADDR_LO: if (w_byte_vld) begin
                    w_load      = 1'b1;
                    w_issue     = 1'b1;
                    w_state_nxt = DONE;
                end
                DONE: w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rw_n     <= 1'b0;
            r_set_addr <= 1'b0;
            r_a16      <= 1'b0;
            r_data     <= 8'h00;
            r_addr_hi  <= 8'h00;
        end else begin
            if (w_cap_cmd) begin
                r_rw_n     <= w_byte[RW_N_BIT];
                r_set_addr <= w_byte[SET_ADDR_BIT];
                r_a16      <= w_byte[A16_BIT];
            end
            if (w_cap_data) r_data    <= w_byte;
            if (w_cap_hi)   r_addr_hi <= w_byte;
        end
    end

    // A dropped request must leave the pending request and the address untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr    <= '0;
            r_valid   <= 1'b0;
            r_we      <= 1'b0;
            r_wr_data <= 8'h00;
            r_overrun <= 1'b0;
            r_rd_buf  <= 8'h00;
        end else begin
            r_overrun <= w_issue & r_valid;
            if (w_issue && !r_valid) begin
                r_valid   <= 1'b1;
                r_we      <= ~w_rw_n;
                r_wr_data <= w_wdat;
                if (w_load) r_addr <= {r_a16, r_addr_hi, w_byte};
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
                r_addr  <= r_addr + ADDR_WIDTH'(1);
                if (!r_we) r_rd_buf <= rd_data_i;
            end
        end
    end

    assign addr_o    = r_addr;
    assign wr_data_o = r_wr_data;
    assign we_o      = r_we;
    assign valid_o   = r_valid;
    assign overrun_o = r_overrun;

    a_clk_ratio: assert property (@(posedge clk_i) RATIO_OK);
endmodule

// File: tb/tb_spi1_target.sv
// Directed bench for spi1_target: SPI host model driving command frames and a manual bus responder.
module tb_spi1_target;
    import spi1_pkg::*;

    localparam int HALF = 64;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        spi_sck_i = 1'b0;
    logic        spi_cs_ni = 1'b1;
    logic        spi_pico_i = 1'b0;
    logic        spi_poci_o;
    logic [16:0] addr_o;
    logic [7:0]  wr_data_o;
    logic        we_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [7:0]  rd_data_i = 8'h00;
    logic        overrun_o;

    int n_chk = 0;
    int n_pass = 0;
    int ovr_cnt = 0;

    spi1_target dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .spi_sck_i  (spi_sck_i),
        .spi_cs_ni  (spi_cs_ni),
        .spi_pico_i (spi_pico_i),
        .spi_poci_o (spi_poci_o),
        .addr_o     (addr_o),
        .wr_data_o  (wr_data_o),
        .we_o       (we_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .rd_data_i  (rd_data_i),
        .overrun_o  (overrun_o)
    );

    always #8 clk_i = ~clk_i;

    always @(posedge clk_i) if (overrun_o === 1'b1) ovr_cnt <= ovr_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            spi_pico_i = tx[i];
            #HALF;
            spi_sck_i = 1'b1;
            rx[i] = spi_poci_o;
            #HALF;
            spi_sck_i = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] bytes, input int n,
                         output logic [7:0] rx0, output logic [7:0] rx1);
        logic [7:0] rx;
        rx0 = 8'h00;
        rx1 = 8'h00;
        spi_cs_ni = 1'b0;
        #(2 * HALF);
        for (int k = 0; k < n; k++) begin
            spi_xfer(bytes[31 - 8 * k -: 8], rx);
            if (k == 0) rx0 = rx;
            if (k == 1) rx1 = rx;
        end
        #HALF;
        spi_cs_ni = 1'b1;
        #(2 * HALF);
        @(negedge clk_i);
    endtask

    task automatic wait_vld(input string tag);
        int k = 0;
        while (valid_o !== 1'b1 && k < 64) begin
            @(negedge clk_i);
            k++;
        end
        check(tag, 32'(valid_o), 32'd1);
    endtask

    task automatic complete(input logic [7:0] rd);
        rd_data_i = rd;
        ready_i   = 1'b1;
        @(negedge clk_i);
        ready_i   = 1'b0;
    endtask

    initial begin
        logic [7:0] r0, r1;
        int o0;

        #2 rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_poci", 32'(spi_poci_o), 32'd0);
        check("rst_addr", 32'(addr_o), 32'h0);
        check("rst_wdat", 32'(wr_data_o), 32'h0);
        check("rst_we", 32'(we_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ovr", 32'(overrun_o), 32'd0);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);

        // write with set_addr, responder late
        frame(32'h4003E80F, 4, r0, r1);
        wait_vld("wr_vld");
        check("wr_addr", 32'(addr_o), 32'h0E80F);
        check("wr_we", 32'(we_o), 32'd1);
        check("wr_wdat", 32'(wr_data_o), 32'h03);
        @(negedge clk_i);
        check("wr_hold_vld", 32'(valid_o), 32'd1);
        check("wr_hold_addr", 32'(addr_o), 32'h0E80F);
        check("wr_hold_wdat", 32'(wr_data_o), 32'h03);
        complete(8'h00);
        check("wr_done_vld", 32'(valid_o), 32'd0);
        check("wr_done_addr", 32'(addr_o), 32'h0E810);

        // read with set_addr, then read_next
        frame(32'hC1234500, 3, r0, r1);
        wait_vld("rd_vld");
        check("rd_addr", 32'(addr_o), 32'h12345);
        check("rd_we", 32'(we_o), 32'd0);
        complete(8'hA5);
        check("rd_done_addr", 32'(addr_o), 32'h12346);
        frame(32'h80000000, 2, r0, r1);
        check("rn_poci_b0", 32'(r0), 32'hA5);
        check("rn_poci_b1", 32'(r1), 32'h00);
        wait_vld("rn_vld");
        check("rn_addr", 32'(addr_o), 32'h12346);
        check("rn_we", 32'(we_o), 32'd0);
        complete(8'h3C);
        check("rn_done_addr", 32'(addr_o), 32'h12347);

        // address wrap
        frame(32'hC1FFFF00, 3, r0, r1);
        wait_vld("wrap_vld");
        check("wrap_top_addr", 32'(addr_o), 32'h1FFFF);
        complete(8'h77);
        check("wrap_addr", 32'(addr_o), 32'h00000);
        frame(32'h80000000, 1, r0, r1);
        check("wrap_poci", 32'(r0), 32'h77);
        wait_vld("wrap_rn_vld");
        check("wrap_rn_addr", 32'(addr_o), 32'h00000);
        complete(8'h5A);
        check("wrap_rn_done", 32'(addr_o), 32'h00001);

        // aborted write frame, then a full one
        o0 = ovr_cnt;
        frame(32'h40990000, 2, r0, r1);
        repeat (8) @(negedge clk_i);
        check("abort_valid", 32'(valid_o), 32'd0);
        check("abort_state", 32'(dut.r_state), 32'(IDLE));
        check("abort_ovr", 32'(ovr_cnt - o0), 32'd0);
        frame(32'h40550010, 4, r0, r1);
        wait_vld("post_abort_vld");
        check("post_abort_addr", 32'(addr_o), 32'h00010);
        check("post_abort_we", 32'(we_o), 32'd1);
        check("post_abort_wdat", 32'(wr_data_o), 32'h55);
        complete(8'h00);
        check("post_abort_done", 32'(addr_o), 32'h00011);

        // overrun: second read_next while first is pending
        frame(32'h80000000, 1, r0, r1);
        check("ovr_poci", 32'(r0), 32'h5A);
        wait_vld("ovr_vld1");
        check("ovr_addr1", 32'(addr_o), 32'h00011);
        o0 = ovr_cnt;
        frame(32'h80000000, 1, r0, r1);
        check("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_still_vld", 32'(valid_o), 32'd1);
        check("ovr_addr_kept", 32'(addr_o), 32'h00011);
        complete(8'h96);
        check("ovr_done_addr", 32'(addr_o), 32'h00012);

        // reset while a request is pending
        frame(32'h80000000, 1, r0, r1);
        check("mr_poci", 32'(r0), 32'h96);
        wait_vld("mr_vld");
        check("mr_addr", 32'(addr_o), 32'h00012);
        #3 rst_ni = 1'b0;
        #1;
        check("mr_async_valid", 32'(valid_o), 32'd0);
        check("mr_async_addr", 32'(addr_o), 32'h0);
        check("mr_async_wdat", 32'(wr_data_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        frame(32'h80000000, 1, r0, r1);
        check("post_rst_poci", 32'(r0), 32'h00);
        wait_vld("post_rst_vld");
        check("post_rst_addr", 32'(addr_o), 32'h00000);
        complete(8'h11);
        frame(32'h40AB0123, 4, r0, r1);
        wait_vld("post_rst_wr_vld");
        check("post_rst_wr_addr", 32'(addr_o), 32'h00123);
        check("post_rst_wr_we", 32'(we_o), 32'd1);
        check("post_rst_wr_wdat", 32'(wr_data_o), 32'hAB);
        complete(8'h00);
        check("post_rst_wr_done", 32'(addr_o), 32'h00124);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
